// File: rtl/camera_capture.sv
// Captures RGB444 pixels from an 8-bit camera byte bus into a FIFO, framed by vsync/href; write lands 2 edges after byte1.
// No backpressure: wfull drops the pixel (overflow, drop_count). `CAPTURE_DROP_CNT_EN enables the drop counter.
module camera_capture #(
    parameter int DATA_WIDTH = 12,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  clk_write,
    input  logic                  rst_n,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            cam_data,
    input  logic                  wfull,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  line_err,
    output logic [15:0]           drop_count
);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_WAIT_VS_LOW = 2'd1;
    localparam logic [1:0] S_ACTIVE      = 2'd2;

    logic                  vs_q, hr_q, vs_prev_q, hr_prev_q;
    logic [7:0]            dat_q;
    logic [1:0]            state_q, state_d;
    logic                  phase_q, phase_d;
    logic [3:0]            r_q, r_d;
    logic [9:0]            x_q, x_d;
    logic [15:0]           y_q, y_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  frame_start_q, frame_start_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;
    logic                  line_err_q, line_err_d;
    logic                  vs_rise, vs_fall, hr_fall;

    assign vs_rise = vs_q & ~vs_prev_q;
    assign vs_fall = ~vs_q & vs_prev_q;
    assign hr_fall = ~hr_q & hr_prev_q;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        r_d           = r_q;
        x_d           = x_q;
        y_d           = y_q;
        write_d       = 1'b0;
        write_data_d  = write_data_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        overflow_d    = overflow_q;
        line_err_d    = line_err_q;
        case (state_q)
            S_IDLE: begin
                if (vs_q) state_d = S_WAIT_VS_LOW;
            end
            S_WAIT_VS_LOW: begin
                if (vs_fall) begin
                    state_d       = S_ACTIVE;
                    frame_start_d = 1'b1;
                    phase_d       = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                    overflow_d    = 1'b0;
                    line_err_d    = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (hr_q) begin
                    if (!phase_q) begin
                        r_d     = dat_q[3:0];
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q != 10'h3FF) x_d = x_q + 10'd1;
                        if (wfull) begin
                            overflow_d = 1'b1;
                        end else begin
                            write_d      = 1'b1;
                            write_data_d = DATA_WIDTH'({r_q, dat_q});
                        end
                    end
                end else if (hr_fall) begin
                    if (phase_q || (x_q != 10'(H_ACTIVE))) line_err_d = 1'b1;
                    phase_d = 1'b0;
                    x_d     = '0;
                    y_d     = y_q + 16'd1;
                    if (y_q + 16'd1 == 16'(V_ACTIVE)) begin
                        frame_done_d = 1'b1;
                        state_d      = S_WAIT_VS_LOW;
                    end
                end
                // A pixel completing alongside the vsync rise is still written above.
                if (vs_rise) begin
                    state_d = S_WAIT_VS_LOW;
                    phase_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= 1'b0;
            hr_q          <= 1'b0;
            dat_q         <= '0;
            vs_prev_q     <= 1'b0;
            hr_prev_q     <= 1'b0;
            state_q       <= S_IDLE;
            phase_q       <= 1'b0;
            r_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            write_q       <= 1'b0;
            write_data_q  <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            vs_q          <= vsync;
            hr_q          <= href;
            dat_q         <= cam_data;
            vs_prev_q     <= vs_q;
            hr_prev_q     <= hr_q;
            state_q       <= state_d;
            phase_q       <= phase_d;
            r_q           <= r_d;
            x_q           <= x_d;
            y_q           <= y_d;
            write_q       <= write_d;
            write_data_q  <= write_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            line_err_q    <= line_err_d;
        end
    end

`ifdef CAPTURE_DROP_CNT_EN
    logic        drop_inc;
    logic [15:0] drop_cnt_q;

    assign drop_inc = (state_q == S_ACTIVE) && hr_q && phase_q && wfull;

    always_ff @(posedge clk_write or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign write       = write_q;
    assign write_data  = write_data_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign line_err    = line_err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with H_ACTIVE=4, V_ACTIVE=2; inputs driven and outputs sampled on the falling edge.
module tb_camera_capture;

    localparam int H = 4;
    localparam int V = 2;
    localparam logic [7:0]  LB [8] = '{8'h0A, 8'hBC, 8'h05, 8'h67, 8'h03, 8'h21, 8'h0F, 8'hFF};
    localparam logic [11:0] EP [4] = '{12'hABC, 12'h567, 12'h321, 12'hFFF};

    logic        clk_write = 1'b0;
    logic        rst_n, vsync, href, wfull;
    logic [7:0]  cam_data;
    logic        write, frame_start, frame_done, overflow, line_err;
    logic [11:0] write_data;
    logic [15:0] drop_count;

    int   n_vec = 0;
    int   n_err = 0;
    logic [11:0] wq[$];
    time  wt[$];
    time  b1_t[$];
    time  hf_t, fd_t;
    int   fs_cnt, fd_cnt;

    always #5 clk_write = ~clk_write;

    camera_capture #(.DATA_WIDTH(12), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_write(clk_write), .rst_n(rst_n), .vsync(vsync), .href(href),
        .cam_data(cam_data), .wfull(wfull), .write(write), .write_data(write_data),
        .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow),
        .line_err(line_err), .drop_count(drop_count)
    );

    always @(negedge clk_write) begin
        if (write) begin
            wq.push_back(write_data);
            wt.push_back($time);
        end
        if (frame_start) fs_cnt++;
        if (frame_done) begin
            fd_cnt++;
            fd_t = $time;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log;
        wq.delete();
        wt.delete();
        b1_t.delete();
        fs_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic do_vsync;
        @(negedge clk_write);
        vsync = 1'b1;
        repeat (3) @(negedge clk_write);
        vsync = 1'b0;
        repeat (4) @(negedge clk_write);
    endtask

    // drop_pix: pixel index whose completion sees wfull; vs_at: byte index where vsync rises.
    task automatic send_line(input int nbytes, input int drop_pix, input int vs_at);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk_write);
            href     = 1'b1;
            cam_data = LB[i % 8];
            wfull    = (drop_pix >= 0) && (i == 2 * drop_pix + 2);
            if (i % 2 == 1) b1_t.push_back($time);
            if (i == vs_at) vsync = 1'b1;
        end
        @(negedge clk_write);
        href     = 1'b0;
        cam_data = 8'h00;
        wfull    = 1'b0;
        hf_t     = $time;
        repeat (5) @(negedge clk_write);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vsync = 1'b1; href = 1'b1; cam_data = 8'hFF; wfull = 1'b0;
        repeat (3) @(negedge clk_write);
        n_vec++; if (write !== 1'b0) begin n_err++; $display("FAIL reset_write got=%b exp=0", write); end
        n_vec++; if (write_data !== 12'h000) begin n_err++; $display("FAIL reset_wdata got=%h exp=000", write_data); end
        n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL reset_lerr got=%b exp=0", line_err); end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        vsync = 1'b0; href = 1'b0; cam_data = 8'h00;
        @(negedge clk_write);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_write);
    endtask

    task automatic test_no_vsync;
        clear_log();
        send_line(8, -1, -1);
        n_vec++; if (wq.size() !== 0) begin n_err++; $display("FAIL novs_writes got=%0d exp=0", wq.size()); end
        n_vec++; if (fs_cnt !== 0) begin n_err++; $display("FAIL novs_fs got=%0d exp=0", fs_cnt); end
    endtask

    task automatic test_single_line;
        logic [11:0] got;
        time         lat;
        clear_log();
        do_vsync();
        n_vec++; if (fs_cnt !== 1) begin n_err++; $display("FAIL line_fs got=%0d exp=1", fs_cnt); end
        send_line(8, -1, -1);
        n_vec++; if (wq.size() !== 4) begin n_err++; $display("FAIL line_count got=%0d exp=4", wq.size()); end
        for (int k = 0; k < 4; k++) begin
            got = (k < wq.size()) ? wq[k] : 12'hxxx;
            lat = (k < wt.size()) ? wt[k] - b1_t[k] : 0;
            n_vec++; if (got !== EP[k]) begin n_err++; $display("FAIL line_pix%0d got=%h exp=%h", k, got, EP[k]); end
            n_vec++; if (lat !== 20) begin n_err++; $display("FAIL line_lat%0d got=%0t exp=20", k, lat); end
        end
        n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL line_lerr got=%b exp=0", line_err); end
        n_vec++; if (fd_cnt !== 0) begin n_err++; $display("FAIL line_fd got=%0d exp=0", fd_cnt); end
    endtask

    task automatic test_frame;
        logic [11:0] got;
        clear_log();
        do_vsync();
        send_line(8, -1, -1);
        n_vec++; if (fd_cnt !== 0) begin n_err++; $display("FAIL frame_fd_early got=%0d exp=0", fd_cnt); end
        send_line(8, -1, -1);
        n_vec++; if (wq.size() !== 8) begin n_err++; $display("FAIL frame_count got=%0d exp=8", wq.size()); end
        for (int k = 0; k < 8; k++) begin
            got = (k < wq.size()) ? wq[k] : 12'hxxx;
            n_vec++; if (got !== EP[k % 4]) begin n_err++; $display("FAIL frame_pix%0d got=%h exp=%h", k, got, EP[k % 4]); end
        end
        n_vec++; if (fs_cnt !== 1) begin n_err++; $display("FAIL frame_fs got=%0d exp=1", fs_cnt); end
        n_vec++; if (fd_cnt !== 1) begin n_err++; $display("FAIL frame_fd got=%0d exp=1", fd_cnt); end
        n_vec++; if (fd_t - hf_t !== 20) begin n_err++; $display("FAIL frame_fd_time got=%0t exp=20", fd_t - hf_t); end
    endtask

    task automatic test_overflow;
        logic [11:0] got;
        logic [11:0] exp3 [3];
        logic [15:0] exp_drop;
        exp3 = '{12'hABC, 12'h321, 12'hFFF};
`ifdef CAPTURE_DROP_CNT_EN
        exp_drop = 16'd1;
`else
        exp_drop = 16'd0;
`endif
        clear_log();
        do_vsync();
        send_line(8, 1, -1);
        n_vec++; if (wq.size() !== 3) begin n_err++; $display("FAIL ovf_count got=%0d exp=3", wq.size()); end
        for (int k = 0; k < 3; k++) begin
            got = (k < wq.size()) ? wq[k] : 12'hxxx;
            n_vec++; if (got !== exp3[k]) begin n_err++; $display("FAIL ovf_pix%0d got=%h exp=%h", k, got, exp3[k]); end
        end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        n_vec++; if (drop_count !== exp_drop) begin n_err++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_count, exp_drop); end
        n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL ovf_lerr got=%b exp=0", line_err); end
    endtask

    task automatic test_short_line;
        clear_log();
        do_vsync();
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL short_ovf_clr got=%b exp=0", overflow); end
        send_line(7, -1, -1);
        n_vec++; if (wq.size() !== 3) begin n_err++; $display("FAIL short_count got=%0d exp=3", wq.size()); end
        n_vec++; if (line_err !== 1'b1) begin n_err++; $display("FAIL short_lerr got=%b exp=1", line_err); end
        do_vsync();
        n_vec++; if (fs_cnt !== 2) begin n_err++; $display("FAIL short_fs got=%0d exp=2", fs_cnt); end
        n_vec++; if (line_err !== 1'b0) begin n_err++; $display("FAIL short_lerr_clr got=%b exp=0", line_err); end
    endtask

    task automatic test_reset_mid_line;
        logic [11:0] got;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_write);
            href     = 1'b1;
            cam_data = LB[i];
            if (i == 1) rst_n = 1'b0;
            if (i == 3) rst_n = 1'b1;
        end
        @(negedge clk_write);
        href = 1'b0;
        repeat (5) @(negedge clk_write);
        send_line(8, -1, -1);
        n_vec++; if (wq.size() !== 0) begin n_err++; $display("FAIL rst_mid_writes got=%0d exp=0", wq.size()); end
        n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_mid_drop got=%0d exp=0", drop_count); end
        do_vsync();
        send_line(8, -1, -1);
        n_vec++; if (wq.size() !== 4) begin n_err++; $display("FAIL rst_mid_resume got=%0d exp=4", wq.size()); end
        got = (wq.size() > 0) ? wq[0] : 12'hxxx;
        n_vec++; if (got !== 12'hABC) begin n_err++; $display("FAIL rst_mid_pix0 got=%h exp=abc", got); end
    endtask

    task automatic test_vsync_collision;
        logic [11:0] got;
        clear_log();
        send_line(8, -1, 3);
        n_vec++; if (wq.size() !== 2) begin n_err++; $display("FAIL coll_count got=%0d exp=2", wq.size()); end
        for (int k = 0; k < 2; k++) begin
            got = (k < wq.size()) ? wq[k] : 12'hxxx;
            n_vec++; if (got !== EP[k]) begin n_err++; $display("FAIL coll_pix%0d got=%h exp=%h", k, got, EP[k]); end
        end
        n_vec++; if (fs_cnt !== 0) begin n_err++; $display("FAIL coll_fs_early got=%0d exp=0", fs_cnt); end
        @(negedge clk_write);
        vsync = 1'b0;
        repeat (4) @(negedge clk_write);
        n_vec++; if (fs_cnt !== 1) begin n_err++; $display("FAIL coll_fs got=%0d exp=1", fs_cnt); end
    endtask

    initial begin
        fs_cnt = 0;
        fd_cnt = 0;
        hf_t   = 0;
        fd_t   = 0;
        test_reset();
        test_no_vsync();
        test_single_line();
        test_frame();
        test_overflow();
        test_short_line();
        test_reset_mid_line();
        test_vsync_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 12: FIFO word width; RGB444 pixel {R,G,B}.
REQ-002 Parameter H_ACTIVE, default 640: pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: lines per frame.
REQ-004 clk_write  input  1: camera pixel clock; the only clock; all logic on rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 vsync  input  1: frame sync, active-high.
REQ-007 href  input  1: line valid, active-high.
REQ-008 cam_data  input  8: camera byte bus.
REQ-009 wfull  input  1: downstream FIFO full.
REQ-010 write  output  1: FIFO write strobe, one cycle per pixel.
REQ-011 write_data  output  DATA_WIDTH: pixel to FIFO.
REQ-012 frame_start  output  1: one-cycle pulse when a frame is armed.
REQ-013 frame_done  output  1: one-cycle pulse after V_ACTIVE complete lines.
REQ-014 overflow  output  1: sticky; a pixel was dropped this frame.
REQ-015 line_err  output  1: sticky; a line ended with a count other than H_ACTIVE, or with an odd byte count.
REQ-016 drop_count  output  16: dropped-pixel counter (see Configuration).

Function
REQ-017 vsync, href and cam_data are registered once; all decisions use the registered copies.
REQ-018 FSM states: IDLE, WAIT_VS_LOW, ACTIVE.
- IDLE -> WAIT_VS_LOW when registered vsync is 1.
- WAIT_VS_LOW -> ACTIVE on vsync 1->0; frame_start pulses that cycle; x/y counters, overflow and line_err clear.
- ACTIVE -> WAIT_VS_LOW on vsync 0->1, abandoning any partial pixel or line.
REQ-019 In ACTIVE with href high, bytes alternate between phases. Byte0 latches R = cam_data[3:0]. Byte1 forms write_data = {R, cam_data[7:0]}.
REQ-020 write is registered and asserts the cycle after byte1 is processed. Latency from the byte1 pin edge to write high is 2 clk_write edges.
REQ-021 write_data holds its last value when write is low. It never changes while write is high.
REQ-022 If wfull is 1 when a pixel completes, that pixel is dropped: write stays 0, overflow sets, drop_count increments. x_count still advances.
REQ-023 x_count (10 bits) increments per completed pixel and saturates at 1023.
REQ-024 On href 1->0:
- an odd byte phase or x_count != H_ACTIVE sets line_err;
- y_count increments, x_count clears and the byte phase resets to byte0.
REQ-025 When y_count reaches V_ACTIVE, frame_done pulses one cycle and the FSM goes to WAIT_VS_LOW.
REQ-026 href outside ACTIVE is ignored: no write is issued.
REQ-027 Simultaneous vsync rise and pixel completion: the pixel is written, then the frame is abandoned.

Reset
REQ-028 While rst_n is 0: state IDLE; all outputs, counters, phases and input registers are 0.
REQ-029 Reset mid-frame discards the partial pixel and line.
REQ-030 After reset, capture begins only after a full vsync high->low sequence.

Configuration
REQ-031 Macro CAPTURE_DROP_CNT_EN defined: drop_count is a 16-bit saturating counter at 65535, cleared only by reset.
REQ-032 Macro CAPTURE_DROP_CNT_EN undefined: drop_count is constant 0 and no counter logic is synthesised. overflow behaves identically in both cases.

Verification
REQ-033 Reset, vsync 1 then 0, one href line with H_ACTIVE=4 and bytes 0x0A,0xBC,0x05,0x67,0x03,0x21,0x0F,0xFF -> writes 0xABC, 0x567, 0x321, 0xFFF; each write 2 edges after its byte1; line_err 0.
REQ-034 Frame with V_ACTIVE=2, H_ACTIVE=4 -> frame_start once, 8 writes, frame_done pulses after the 2nd href fall.
REQ-035 wfull high for the 2nd pixel of a line -> 3 writes; overflow 1; drop_count 1 with the macro, 0 without.
REQ-036 Line of 7 bytes -> 3 writes and line_err 1. The next frame_start clears line_err.
REQ-037 rst_n low mid-line, then href continues with no vsync -> write stays 0 until a vsync high->low and a new line.
REQ-038 href pulses before the first vsync after reset -> no write, frame_start stays 0.
